// File: rtl/nor_unit_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit NOR unit among NUM_REQ
// requesters; each operation runs IDLE -> EXEC -> RESP with a one-cycle ack.
module nor_unit_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         y,
  output logic                     y_valid,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     op_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]     a_lat_q, a_lat_d;
  logic [WIDTH-1:0]     b_lat_q, b_lat_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        cur_q, cur_d;
  logic [CNT_WIDTH-1:0] op_cnt_q, op_cnt_d;

  logic                 win_found;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        cand;
  logic [NUM_REQ-1:0]   win_oh;
  logic [WIDTH-1:0]     a_sel, b_sel;

  // Search starts one past the last winner and wraps, so the previous winner
  // is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_oh = '0;
    if (win_found) begin
      win_oh[win_idx] = 1'b1;
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        a_sel = a_in[i*WIDTH +: WIDTH];
        b_sel = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      y_q      <= '0;
      ptr_q    <= PW'(NUM_REQ - 1);
      cur_q    <= '0;
      op_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      a_lat_q  <= a_lat_d;
      b_lat_q  <= b_lat_d;
      y_q      <= y_d;
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    a_lat_d  = a_lat_q;
    b_lat_d  = b_lat_q;
    y_d      = y_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    op_cnt_d = op_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = win_oh;
          a_lat_d = a_sel;
          b_lat_d = b_sel;
          cur_d   = win_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        y_d     = ~(a_lat_q | b_lat_q);
        state_d = RESP;
      end
      RESP: begin
        op_cnt_d = op_cnt_q + CNT_WIDTH'(1);
        ptr_d    = cur_q;
        gnt_d    = '0;
        state_d  = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ack     = (state_q == RESP) ? gnt_q : '0;
    y_valid = (state_q == RESP);
    busy    = (state_q != IDLE);
    gnt     = gnt_q;
    y       = y_q;
    op_cnt  = op_cnt_q;
  end

endmodule

// File: tb/tb_nor_unit_arbiter.sv
// Self-checking bench for nor_unit_arbiter: directed table, corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_nor_unit_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in, b_in;
  logic [N-1:0]     gnt, ack, gnt2, ack2;
  logic [W-1:0]     y, y2;
  logic             y_valid, busy, y_valid2, busy2;
  logic [CW-1:0]    op_cnt;
  logic [1:0]       op_cnt2;

  nor_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .ack(ack), .y(y), .y_valid(y_valid), .busy(busy), .op_cnt(op_cnt)
  );

  nor_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt2), .ack(ack2), .y(y2), .y_valid(y_valid2), .busy(busy2), .op_cnt(op_cnt2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks which cycle of an operation we are in and what
  // the round-robin rule says the winner and result must be.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (((r >> ((last + k) % N)) & N'(1)) != '0) return (last + k) % N;
    end
    return 0;
  endfunction

  int          m_phase, m_last, m_win;
  logic [N-1:0] m_gnt;
  logic [W-1:0] m_a, m_b, m_y;
  int unsigned  m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_last  <= N - 1;
      m_win   <= 0;
      m_gnt   <= '0;
      m_y     <= '0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: if (req != '0) begin
          m_win   <= rr_pick(req, m_last);
          m_gnt   <= N'(1) << rr_pick(req, m_last);
          m_a     <= W'(a_in >> (rr_pick(req, m_last) * W));
          m_b     <= W'(b_in >> (rr_pick(req, m_last) * W));
          m_phase <= 1;
        end
        1: begin
          m_y     <= ~(m_a | m_b);
          m_phase <= 2;
        end
        default: begin
          m_cnt   <= m_cnt + 1;
          m_last  <= m_win;
          m_gnt   <= '0;
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    #2;
    check("m_gnt",     32'(gnt),     32'(m_gnt));
    check("m_ack",     32'(ack),     (m_phase == 2) ? 32'(m_gnt) : 32'd0);
    check("m_y",       32'(y),       32'(m_y));
    check("m_y_valid", 32'(y_valid), (m_phase == 2) ? 32'd1 : 32'd0);
    check("m_busy",    32'(busy),    (m_phase != 0) ? 32'd1 : 32'd0);
    check("m_op_cnt",  32'(op_cnt),  m_cnt % 65536);
    check("m_op_cnt2", 32'(op_cnt2), m_cnt % 4);
    check("m_gnt2",    32'(gnt2),    32'(m_gnt));
  end

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N-1:0]   gnt;
    logic [W-1:0]   y;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack != '0) begin
        ok = 1'b1;
        return;
      end
    end
    check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int last_ack_t;
    logic [1:0] wrap_exp [5];
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    tbl[0] = '{4'b0010, 32'h0000_0F00, 32'h0000_F000, 4'b0010, 8'h00};
    tbl[1] = '{4'b0010, 32'h0000_0000, 32'h0000_0000, 4'b0010, 8'hFF};
    tbl[2] = '{4'b1111, 32'h3322_1100, 32'h0000_0000, 4'b0100, 8'hDD};
    tbl[3] = '{4'b1001, 32'h3000_0000, 32'h0300_0000, 4'b1000, 8'hCC};
    tbl[4] = '{4'b1001, 32'h0000_00A0, 32'h0000_0005, 4'b0001, 8'h5A};
    tbl[5] = '{4'b0001, 32'h0000_00FF, 32'h0000_0000, 4'b0001, 8'h00};

    // Reset with every requester asking, distinct operands per requester
    rst_n = 1'b0;
    req   = '1;
    a_in  = 32'h3322_1100;
    b_in  = '0;
    repeat (3) step();
    check("rst_gnt",    32'(gnt),    32'd0);
    check("rst_ack",    32'(ack),    32'd0);
    check("rst_y",      32'(y),      32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    check("first_gnt", 32'(gnt), 32'b0001);

    // Fairness: continuous requests are served 0,1,2,3,0 three cycles apart
    last_ack_t = 0;
    for (int j = 0; j < 5; j++) begin
      wait_ack(ok);
      if (ok) begin
        check("fair_ack", 32'(ack), 32'(1) << (j % 4));
        check("fair_y",   32'(y),   32'(8'(~(8'h11 * (j % 4)))));
        if (j > 0) check("fair_spacing", 32'($time - last_ack_t), 32'd30);
        last_ack_t = int'($time);
      end
      if (j == 4) req = '0;
    end
    step();

    // Directed table; round-robin pointer carries over between entries
    for (int i = 0; i < 6; i++) begin
      req  = tbl[i].req;
      a_in = tbl[i].a;
      b_in = tbl[i].b;
      step();
      check("tbl_gnt",  32'(gnt),  32'(tbl[i].gnt));
      check("tbl_busy", 32'(busy), 32'd1);
      step();
      check("tbl_ack",  32'(ack),     32'(tbl[i].gnt));
      check("tbl_y",    32'(y),       32'(tbl[i].y));
      check("tbl_yv",   32'(y_valid), 32'd1);
      req = '0;
      step();
      check("tbl_idle", 32'(busy), 32'd0);
      check("tbl_hold_y", 32'(y), 32'(tbl[i].y));
    end

    // Operand change during EXEC must not affect the result
    req  = 4'b0100;
    a_in = 32'h0055_0000;
    b_in = '0;
    step();
    check("stab_gnt", 32'(gnt), 32'b0100);
    a_in = 32'h00FF_0000;
    step();
    check("stab_ack", 32'(ack), 32'b0100);
    check("stab_y",   32'(y),   32'hAA);
    req = '0;
    step();

    // Withdrawal during EXEC, then a request raised during RESP
    req  = 4'b1000;
    a_in = 32'h0F00_0100;
    step();
    check("wd_gnt", 32'(gnt), 32'b1000);
    req = '0;
    step();
    check("wd_ack", 32'(ack), 32'b1000);
    check("wd_y",   32'(y),   32'hF0);
    req = 4'b0010;
    step();
    check("pend_idle_gnt", 32'(gnt), 32'd0);
    check("pend_idle_busy", 32'(busy), 32'd0);
    step();
    check("pend_gnt", 32'(gnt), 32'b0010);
    step();
    check("pend_ack", 32'(ack), 32'b0010);
    check("pend_y",   32'(y),   32'hFE);
    req = '0;
    step();

    // Reset during EXEC aborts the operation
    req  = 4'b0001;
    a_in = '0;
    step();
    check("abort_gnt_pre", 32'(gnt), 32'b0001);
    rst_n = 1'b0;
    #1;
    check("abort_gnt",    32'(gnt),    32'd0);
    check("abort_ack",    32'(ack),    32'd0);
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_y",      32'(y),      32'd0);
    check("abort_op_cnt", 32'(op_cnt), 32'd0);
    req = '0;
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("abort_no_ack", 32'(ack), 32'd0);
    end

    // Counter wrap on the 2-bit instance
    for (int k = 0; k < 5; k++) begin
      req = 4'b0001;
      step();
      step();
      req = '0;
      step();
      check("wrap_cnt2", 32'(op_cnt2), 32'(wrap_exp[k]));
      check("wrap_cnt",  32'(op_cnt),  32'(k + 1));
    end

    // Randomized traffic with occasional resets, checked by the model
    for (int c = 0; c < 600; c++) begin
      step();
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      req   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
      a_in  = $urandom;
      b_in  = $urandom;
    end
    rst_n = 1'b1;
    req   = '0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
